// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered per-channel reset release with divided clock enables and req/ack soft reset.
// Optional RST_SEQ_REVERSE_ASSERT_EN re-asserts channels in reverse order on soft reset.
module rst_seq_gen #(
  parameter int NUM_CH     = 4,
  parameter int RST_CYCLES = 6,
  parameter int STAGE_GAP  = 2,
  parameter int DIV_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    soft_rst_req_i,
  output logic                    soft_rst_ack_o,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       rst_no,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic                    seq_done_o,
  output logic                    busy_o
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  if (RST_CYCLES > (1 << CNT_W) - 1 || STAGE_GAP > (1 << CNT_W) - 1) begin : g_bad_cnt_w
    $error("rst_seq_gen: CNT_W too narrow for RST_CYCLES/STAGE_GAP");
  end
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, ASSERT} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ch_idx;
  logic [NUM_CH-1:0] kill;
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] dcnt  [NUM_CH];
  logic [DIV_W-1:0] last  [NUM_CH];
  // kill marks channels whose reset drops on this edge, so their enables clear on the same edge
  always_comb begin
    kill = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    for (int k = 0; k < NUM_CH; k++)
      kill[k] = state == ASSERT && cnt == '0 && ch_idx == IDX_W'(k);
`else
    kill = {NUM_CH{state == RUN && soft_rst_req_i}};
`endif
    for (int k = 0; k < NUM_CH; k++)
      last[k] = div_q[k] == '0 ? '0 : div_q[k] - 1'b1;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state          <= HOLD;
      cnt            <= '0;
      ch_idx         <= '0;
      rst_no         <= '0;
      seq_done_o     <= 1'b0;
      busy_o         <= 1'b1;
      soft_rst_ack_o <= 1'b0;
    end else begin
      soft_rst_ack_o <= 1'b0;
      case (state)
        HOLD:
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            rst_no[0] <= 1'b1;
            cnt       <= '0;
            ch_idx    <= NUM_CH == 1 ? '0 : IDX_W'(1);
            if (NUM_CH == 1) begin
              state      <= RUN;
              seq_done_o <= 1'b1;
              busy_o     <= 1'b0;
            end else state <= RELEASE;
          end else cnt <= cnt + 1'b1;
        RELEASE:
          if (cnt == CNT_W'(STAGE_GAP - 1)) begin
            rst_no[ch_idx] <= 1'b1;
            cnt            <= '0;
            if (ch_idx == IDX_W'(NUM_CH - 1)) begin
              ch_idx     <= '0;
              state      <= RUN;
              seq_done_o <= 1'b1;
              busy_o     <= 1'b0;
            end else ch_idx <= ch_idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        RUN:
          if (soft_rst_req_i) begin
            soft_rst_ack_o <= 1'b1;
            seq_done_o     <= 1'b0;
            busy_o         <= 1'b1;
            cnt            <= '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            state  <= ASSERT;
            ch_idx <= IDX_W'(NUM_CH - 1);
`else
            state  <= HOLD;
            ch_idx <= '0;
            rst_no <= '0;
`endif
          end
        default: begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          cnt <= cnt == CNT_W'(STAGE_GAP - 1) ? '0 : cnt + 1'b1;
          if (cnt == '0) begin
            rst_no[ch_idx] <= 1'b0;
            if (ch_idx == '0) begin
              state <= HOLD;
              cnt   <= '0;
            end else ch_idx <= ch_idx - 1'b1;
          end
`else
          state <= HOLD;
          cnt   <= '0;
`endif
        end
      endcase
    end
  // divide ratio keeps loading while a channel is in reset, freezing at the release edge
  always_ff @(posedge clk_i)
    for (int k = 0; k < NUM_CH; k++)
      if (rst_i || !rst_no[k] || kill[k]) begin
        clk_en_o[k] <= 1'b0;
        dcnt[k]     <= '0;
        div_q[k]    <= div_i[k*DIV_W +: DIV_W];
      end else begin
        clk_en_o[k] <= dcnt[k] == last[k];
        dcnt[k]     <= dcnt[k] == last[k] ? '0 : dcnt[k] + 1'b1;
      end
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed self-checking bench for rst_seq_gen (NUM_CH=4, RST_CYCLES=6, STAGE_GAP=2).
module tb_rst_seq_gen;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        soft_rst_req_i = 1'b0;
  logic [15:0] div_i = 16'h1032;
  logic        soft_rst_ack_o, seq_done_o, busy_o;
  logic [3:0]  rst_no, clk_en_o;
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  rst_seq_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .soft_rst_req_i(soft_rst_req_i),
    .soft_rst_ack_o(soft_rst_ack_o), .div_i(div_i), .rst_no(rst_no),
    .clk_en_o(clk_en_o), .seq_done_o(seq_done_o), .busy_o(busy_o)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst_vals(input string tag);
    chk({tag, "_rst_no"}, 32'(rst_no), 32'h0);
    chk({tag, "_en"}, 32'(clk_en_o), 32'h0);
    chk({tag, "_done"}, 32'(seq_done_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h1);
    chk({tag, "_ack"}, 32'(soft_rst_ack_o), 32'h0);
  endtask
  function automatic logic [3:0] rel_mask(input int e, input int base);
    for (int k = 0; k < 4; k++) rel_mask[k] = e >= base + 6 + 2 * k;
  endfunction
  // ratios 2,3,0(->1),1 for channels 0..3, released on edges 6,8,10,12
  function automatic logic [3:0] en_exp(input int e);
    int dv [4] = '{2, 3, 1, 1};
    for (int k = 0; k < 4; k++) en_exp[k] = e > 6 + 2 * k && (e - 6 - 2 * k) % dv[k] == 0;
  endfunction
  initial begin
    int base;
    int t;
    logic [3:0] m;
    repeat (3) tick;
    chk_rst_vals("por");
    rst_i = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick;
      if (e == 13) div_i = 16'hFFFF;
      chk("rel_rst", 32'(rst_no), 32'(rel_mask(e, 0)));
      chk("rel_en", 32'(clk_en_o), 32'(en_exp(e)));
      chk("rel_done", 32'(seq_done_o), 32'(e >= 12));
      chk("rel_busy", 32'(busy_o), 32'(e < 12));
      chk("rel_ack", 32'(soft_rst_ack_o), 32'h0);
    end
    soft_rst_req_i = 1'b1;
    tick;
    soft_rst_req_i = 1'b0;
    chk("sr_ack", 32'(soft_rst_ack_o), 32'h1);
    chk("sr_rst", 32'(rst_no), REV ? 32'hF : 32'h0);
    chk("sr_en", 32'(clk_en_o), REV ? 32'(en_exp(25)) : 32'h0);
    chk("sr_done", 32'(seq_done_o), 32'h0);
    chk("sr_busy", 32'(busy_o), 32'h1);
    base = REV ? 7 : 0;
    for (int j = 1; j <= base + 12; j++) begin
      tick;
      for (int k = 0; k < 4; k++) m[k] = (REV && j < 1 + 2 * (3 - k)) || j >= base + 6 + 2 * k;
      chk("rerun_rst", 32'(rst_no), 32'(m));
      chk("rerun_ack", 32'(soft_rst_ack_o), 32'h0);
      chk("rerun_done", 32'(seq_done_o), 32'(j >= base + 12));
      chk("rerun_busy", 32'(busy_o), 32'(j < base + 12));
    end
    rst_i = 1'b1;
    tick;
    chk_rst_vals("run_rst");
    rst_i = 1'b0;
    for (int e = 1; e <= 9; e++) tick;
    chk("mid_rst_no", 32'(rst_no), 32'h3);
    rst_i = 1'b1;
    tick;
    chk_rst_vals("pulse");
    rst_i = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick;
      chk("early_rst", 32'(rst_no), e < 13 ? 32'(rel_mask(e, 0)) : (REV ? 32'hF : 32'h0));
      chk("early_ack", 32'(soft_rst_ack_o), 32'(e == 13));
      chk("early_done", 32'(seq_done_o), 32'(e == 12));
      chk("early_busy", 32'(busy_o), 32'(e < 12 || e == 13));
      if (e == 7) soft_rst_req_i = 1'b1;
    end
    soft_rst_req_i = 1'b0;
    t = 0;
    while (!seq_done_o && t < 60) begin
      tick;
      t++;
    end
    chk("done_timeout", 32'(seq_done_o), 32'h1);
    rst_i = 1'b1;
    soft_rst_req_i = 1'b1;
    tick;
    chk_rst_vals("rst_req");
    rst_i = 1'b0;
    soft_rst_req_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
